// File: rtl/hci_core_mux_static_drain_if.sv
// HCI core package defaults and the hci_core_intf bundle shared by
// initiators and targets of hci_core_mux_static_drain.
package hci_package;
  parameter int unsigned DEFAULT_DW = 32;
  parameter int unsigned DEFAULT_AW = 32;
  parameter int unsigned DEFAULT_BW = 8;
  parameter int unsigned DEFAULT_WW = 32;
endpackage

interface hci_core_intf #(
  parameter int unsigned DW = hci_package::DEFAULT_DW,
  parameter int unsigned AW = hci_package::DEFAULT_AW,
  parameter int unsigned BW = hci_package::DEFAULT_BW,
  parameter int unsigned WW = hci_package::DEFAULT_WW,
  parameter int unsigned OW = AW
);
  logic                       req;
  logic                       gnt;
  logic [AW-1:0]              add;
  logic                       wen;
  logic [DW-1:0]              data;
  logic [DW/BW-1:0]           be;
  logic [DW/WW-1:0][OW-1:0]   boffs;
  logic                       lrdy;
  logic [DW-1:0]              r_data;
  logic                       r_valid;
  logic                       r_opc;

  modport master (
    output req, add, wen, data, be, boffs, lrdy,
    input  gnt, r_data, r_valid, r_opc
  );
  modport slave (
    input  req, add, wen, data, be, boffs, lrdy,
    output gnt, r_data, r_valid, r_opc
  );
endinterface

// File: rtl/hci_core_mux_static_drain.sv
// Static N-way HCI mux that only commits a select change once every granted
// transaction on the old channel has answered. Option: HCI_CORE_MUX_STATIC_DRAIN_CHECK_EN.
`ifdef HCI_CORE_MUX_STATIC_DRAIN_CHECK_EN
module hci_core_mux_static_drain_chk #(
  parameter int unsigned NB_CHAN = 2,
  parameter int unsigned PW      = 1
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic                clear_i,
  input logic [NB_CHAN-1:0]  req,
  input logic [NB_CHAN-1:0]  gnt,
  input logic [PW-1:0]       payload [NB_CHAN]
);
  for (genvar k = 0; k < NB_CHAN; k++) begin : g_chk
    stable_blocked_req: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
      (req[k] && !gnt[k]) ##1 req[k] |-> $stable(payload[k]))
      else $error("channel %0d changed a blocked request", k);
  end
endmodule
`endif

module hci_core_mux_static_drain #(
  parameter int unsigned NB_CHAN         = 2,
  parameter int unsigned DW              = hci_package::DEFAULT_DW,
  parameter int unsigned AW              = hci_package::DEFAULT_AW,
  parameter int unsigned BW              = hci_package::DEFAULT_BW,
  parameter int unsigned WW              = hci_package::DEFAULT_WW,
  parameter int unsigned OW              = AW,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SW              = $clog2(NB_CHAN)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clear_i,
  input  logic [SW-1:0]                          sel_i,
  hci_core_intf.slave                            in [NB_CHAN-1:0],
  hci_core_intf.master                           out,
  output logic [SW-1:0]                          active_sel_o,
  output logic                                   busy_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
`ifdef HCI_CORE_MUX_STATIC_DRAIN_CHECK_EN
  ,
  output logic                                   err_o
`endif
);
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned NP  = 1 << SW;
  localparam int unsigned BEW = DW / BW;
  localparam int unsigned NBO = DW / WW;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_e;

  state_e                 state_q;
  logic [SW-1:0]          sel_q;
  logic [SW-1:0]          target_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_next;
  logic                   fwd_s;
  logic                   inc_s;
  logic                   dec_s;

  // Select-indexed copies; entries past NB_CHAN are tied off so any sel_q value indexes safely
  logic [NP-1:0]          req_s;
  logic [NP-1:0]          wen_s;
  logic [NP-1:0]          lrdy_s;
  logic [NP-1:0]          gnt_s;
  logic [AW-1:0]          add_s   [NP];
  logic [DW-1:0]          data_s  [NP];
  logic [BEW-1:0]         be_s    [NP];
  logic [NBO-1:0][OW-1:0] boffs_s [NP];

  for (genvar k = 0; k < NB_CHAN; k++) begin : g_chan
    assign req_s[k]      = in[k].req;
    assign wen_s[k]      = in[k].wen;
    assign lrdy_s[k]     = in[k].lrdy;
    assign add_s[k]      = in[k].add;
    assign data_s[k]     = in[k].data;
    assign be_s[k]       = in[k].be;
    assign boffs_s[k]    = in[k].boffs;
    assign gnt_s[k]      = fwd_s & (sel_q == SW'(k)) & out.gnt;
    assign in[k].gnt     = gnt_s[k];
    assign in[k].r_valid = (sel_q == SW'(k)) & out.r_valid;
    assign in[k].r_data  = out.r_data;
    assign in[k].r_opc   = out.r_opc;
  end

  for (genvar k = NB_CHAN; k < NP; k++) begin : g_pad
    assign req_s[k]   = 1'b0;
    assign wen_s[k]   = 1'b0;
    assign lrdy_s[k]  = 1'b0;
    assign gnt_s[k]   = 1'b0;
    assign add_s[k]   = '0;
    assign data_s[k]  = '0;
    assign be_s[k]    = '0;
    assign boffs_s[k] = '0;
  end

  assign fwd_s = (state_q == RUN) && (sel_i == sel_q) && (cnt_q < MAX_CNT);

  assign out.req   = fwd_s & req_s[sel_q];
  assign out.add   = add_s[sel_q];
  assign out.wen   = wen_s[sel_q];
  assign out.data  = data_s[sel_q];
  assign out.be    = be_s[sel_q];
  assign out.boffs = boffs_s[sel_q];
  assign out.lrdy  = lrdy_s[sel_q];

  assign inc_s = fwd_s & req_s[sel_q] & out.gnt;
  // A response with nothing outstanding is an underflow and must not wrap the count
  assign dec_s = out.r_valid & (cnt_q != '0);

  // Post-update outstanding count
  always_comb begin
    cnt_next = cnt_q;
    case ({inc_s, dec_s})
      2'b10:   cnt_next = cnt_q + CW'(1);
      2'b01:   cnt_next = cnt_q - CW'(1);
      default: cnt_next = cnt_q;
    endcase
  end

  // Select FSM: switch immediately when idle, otherwise drain the old channel first
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      sel_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      state_q  <= RUN;
      sel_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_next;
      case (state_q)
        RUN: begin
          if (sel_i != sel_q) begin
            if (cnt_next == '0) begin
              sel_q <= sel_i;
            end else begin
              target_q <= sel_i;
              state_q  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt_next == '0) begin
            sel_q   <= target_q;
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign active_sel_o  = sel_q;
  assign busy_o        = (state_q == DRAIN);
  assign outstanding_o = cnt_q;

`ifdef HCI_CORE_MUX_STATIC_DRAIN_CHECK_EN
  localparam int unsigned PW = AW + 1 + BEW + DW;
  logic       err_q;
  logic [PW-1:0] payload_s [NB_CHAN];

  // Sticky underflow flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (clear_i) begin
      err_q <= 1'b0;
    end else if (out.r_valid && (cnt_q == '0)) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign err_o = err_q;

  for (genvar k = 0; k < NB_CHAN; k++) begin : g_payload
    assign payload_s[k] = {add_s[k], wen_s[k], be_s[k], data_s[k]};
  end

  hci_core_mux_static_drain_chk #(
    .NB_CHAN (NB_CHAN),
    .PW      (PW)
  ) i_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .req     (req_s[NB_CHAN-1:0]),
    .gnt     (gnt_s[NB_CHAN-1:0]),
    .payload (payload_s)
  );
`endif

endmodule

// File: tb/tb_hci_core_mux_static_drain.sv
// Randomized and directed bench for hci_core_mux_static_drain against a
// counter/pending-target reference model.
module tb_hci_core_mux_static_drain;
  localparam int NB = 3, MAXO = 4, DW = 32, AW = 32, BW = 8, WW = 32;
  localparam int SW = 2, CW = 3, BEW = DW / BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic [SW-1:0]   sel = '0;
  logic [NB-1:0]   i_req = '0, i_wen = '0, i_lrdy = '0, i_gnt, i_rvalid, i_ropc;
  logic [AW-1:0]   i_add [NB];
  logic [AW-1:0]   i_boffs [NB];
  logic [DW-1:0]   i_data [NB];
  logic [BEW-1:0]  i_be [NB];
  logic [DW-1:0]   i_rdata [NB];
  logic            o_gnt = 1'b0, o_rvalid = 1'b0, o_ropc = 1'b0;
  logic [DW-1:0]   o_rdata = '0;
  logic            o_req, o_wen, o_lrdy;
  logic [AW-1:0]   o_add, o_boffs;
  logic [DW-1:0]   o_data;
  logic [BEW-1:0]  o_be;
  logic [SW-1:0]   active_sel;
  logic            busy;
  logic [CW-1:0]   outstanding;
`ifdef HCI_CORE_MUX_STATIC_DRAIN_CHECK_EN
  logic            err;
`endif

  hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .WW(WW)) in_if [NB-1:0] ();
  hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .WW(WW)) out_if ();

  for (genvar k = 0; k < NB; k++) begin : g_if
    assign in_if[k].req   = i_req[k];
    assign in_if[k].wen   = i_wen[k];
    assign in_if[k].lrdy  = i_lrdy[k];
    assign in_if[k].add   = i_add[k];
    assign in_if[k].data  = i_data[k];
    assign in_if[k].be    = i_be[k];
    assign in_if[k].boffs = i_boffs[k];
    assign i_gnt[k]       = in_if[k].gnt;
    assign i_rvalid[k]    = in_if[k].r_valid;
    assign i_rdata[k]     = in_if[k].r_data;
    assign i_ropc[k]      = in_if[k].r_opc;
  end
  assign o_req          = out_if.req;
  assign o_wen          = out_if.wen;
  assign o_lrdy         = out_if.lrdy;
  assign o_add          = out_if.add;
  assign o_data         = out_if.data;
  assign o_be           = out_if.be;
  assign o_boffs        = out_if.boffs;
  assign out_if.gnt     = o_gnt;
  assign out_if.r_valid = o_rvalid;
  assign out_if.r_data  = o_rdata;
  assign out_if.r_opc   = o_ropc;

  hci_core_mux_static_drain #(
    .NB_CHAN(NB), .DW(DW), .AW(AW), .BW(BW), .WW(WW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .sel_i         (sel),
    .in            (in_if),
    .out           (out_if),
    .active_sel_o  (active_sel),
    .busy_o        (busy),
    .outstanding_o (outstanding)
`ifdef HCI_CORE_MUX_STATIC_DRAIN_CHECK_EN
    ,
    .err_o         (err)
`endif
  );

  int n_tests = 0, n_fail = 0;
  // Reference model: committed channel, pending switch target (-1 = none), count, sticky error
  int m_sel, m_tgt, m_cnt, n_grants;
  int rv_cnt [NB];
  bit m_err;
  logic [NB-1:0] hold = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_sel = 0; m_tgt = -1; m_cnt = 0; m_err = 1'b0;
  endfunction

  function automatic bit m_open();
    return (m_tgt < 0) && (int'(sel) == m_sel) && (m_cnt < MAXO);
  endfunction

  task automatic compare_all();
    bit open;
    open = m_open();
    check_eq("out_req", o_req, open && i_req[m_sel]);
    check_eq("out_add", o_add, i_add[m_sel]);
    check_eq("out_data", o_data, i_data[m_sel]);
    check_eq("out_be", o_be, i_be[m_sel]);
    check_eq("out_wen", o_wen, i_wen[m_sel]);
    check_eq("out_lrdy", o_lrdy, i_lrdy[m_sel]);
    check_eq("out_boffs", o_boffs, i_boffs[m_sel]);
    for (int k = 0; k < NB; k++) begin
      check_eq("in_gnt", i_gnt[k], open && (k == m_sel) && o_gnt);
      check_eq("in_rvalid", i_rvalid[k], (k == m_sel) && o_rvalid);
      check_eq("in_rdata", i_rdata[k], o_rdata);
      check_eq("in_ropc", i_ropc[k], o_ropc);
      if (i_rvalid[k]) rv_cnt[k]++;
      hold[k] = i_req[k] && !i_gnt[k];
    end
    check_eq("busy", busy, m_tgt >= 0);
    check_eq("active_sel", active_sel, m_sel);
    check_eq("outstanding", outstanding, m_cnt);
`ifdef HCI_CORE_MUX_STATIC_DRAIN_CHECK_EN
    check_eq("err", err, m_err);
`endif
    if (o_req && o_gnt) n_grants++;
  endtask

  task automatic m_step();
    bit inc, dec;
    if (clear) begin
      m_reset();
      return;
    end
    inc = m_open() && i_req[m_sel] && o_gnt;
    dec = o_rvalid;
    if (dec && m_cnt == 0) m_err = 1'b1;
    m_cnt = m_cnt + int'(inc) - int'(dec && m_cnt > 0);
    if (m_tgt < 0) begin
      if (int'(sel) != m_sel) begin
        if (m_cnt == 0) m_sel = int'(sel);
        else m_tgt = int'(sel);
      end
    end else if (m_cnt == 0) begin
      m_sel = m_tgt;
      m_tgt = -1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle();
    i_req = '0; o_gnt = 1'b0; o_rvalid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; sel = '0;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    for (int k = 0; k < NB; k++) begin
      i_add[k] = 32'h1000 * (k + 1); i_data[k] = $urandom; i_be[k] = 4'hF;
      i_boffs[k] = $urandom; i_wen[k] = 1'b1;
    end
    m_reset();
    do_reset();
    check_eq("rst_active_sel", active_sel, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_outstanding", outstanding, 0);
    check_eq("rst_out_req", o_req, 0);

    // Three reads on channel 0, then switch to 1 with responses at +2, +5, +7
    for (int k = 0; k < NB; k++) rv_cnt[k] = 0;
    i_req[0] = 1'b1; o_gnt = 1'b1;
    repeat (3) tick();
    check_eq("t1_outstanding", outstanding, 3);
    i_req[0] = 1'b0; i_req[1] = 1'b1; sel = 2'd1;
    tick();
    check_eq("t1_busy", busy, 1);
    check_eq("t1_blocked", o_req, 0);
    for (int c = 1; c <= 7; c++) begin
      o_rvalid = (c == 2 || c == 5 || c == 7);
      tick();
      check_eq("t1_active_sel", active_sel, (c == 7) ? 1 : 0);
    end
    o_rvalid = 1'b0;
    check_eq("t1_busy_done", busy, 0);
    check_eq("t1_rv0", rv_cnt[0], 3);
    check_eq("t1_rv1", rv_cnt[1], 0);

    // Full at MAX_OUTSTANDING, one response reopens a single grant
    do_reset();
    i_req[0] = 1'b1; o_gnt = 1'b1; n_grants = 0;
    repeat (6) tick();
    check_eq("t2_grants", n_grants, 4);
    check_eq("t2_full_block", o_req, 0);
    o_rvalid = 1'b1;
    tick();
    o_rvalid = 1'b0;
    check_eq("t2_grants_rv", n_grants, 4);
    tick();
    check_eq("t2_grants_after", n_grants, 5);

    // Simultaneous grant/response, then commit in the cycle of the last response
    do_reset();
    i_req[0] = 1'b1; o_gnt = 1'b1;
    repeat (2) tick();
    o_rvalid = 1'b1;
    tick();
    check_eq("t3_same_cycle", outstanding, 2);
    i_req[0] = 1'b0;
    tick();
    check_eq("t3_cnt1", outstanding, 1);
    o_rvalid = 1'b0; sel = 2'd1;
    tick();
    check_eq("t3_busy", busy, 1);
    o_rvalid = 1'b1;
    tick();
    o_rvalid = 1'b0;
    check_eq("t3_commit", active_sel, 1);
    check_eq("t3_cnt0", outstanding, 0);

    // Select moves during drain, then clear mid-drain and a late response
    do_reset();
    i_req[0] = 1'b1; o_gnt = 1'b1;
    repeat (2) tick();
    i_req[0] = 1'b0; sel = 2'd1;
    tick();
    sel = 2'd2;
    tick();
    o_rvalid = 1'b1;
    repeat (2) tick();
    o_rvalid = 1'b0;
    check_eq("t4_first_commit", active_sel, 1);
    tick();
    check_eq("t4_second_commit", active_sel, 2);
    i_req[2] = 1'b1;
    repeat (2) tick();
    i_req[2] = 1'b0; sel = 2'd0;
    tick();
    check_eq("t4_drain", busy, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("t4_clr_sel", active_sel, 0);
    check_eq("t4_clr_busy", busy, 0);
    check_eq("t4_clr_cnt", outstanding, 0);
    o_rvalid = 1'b1;
    tick();
    o_rvalid = 1'b0;
    check_eq("t4_underflow_cnt", outstanding, 0);
`ifdef HCI_CORE_MUX_STATIC_DRAIN_CHECK_EN
    check_eq("t4_err_set", err, 1);
    repeat (3) tick();
    check_eq("t4_err_sticky", err, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("t4_err_clr", err, 0);
`endif

    // Randomized traffic; a blocked request is held stable until granted
    do_reset();
    hold = '0;
    repeat (3000) begin
      for (int k = 0; k < NB; k++) begin
        if (!hold[k]) begin
          i_req[k] = 1'($urandom_range(0, 1)); i_wen[k] = 1'($urandom_range(0, 1));
          i_add[k] = $urandom; i_data[k] = $urandom; i_be[k] = 4'($urandom);
        end
        i_lrdy[k] = 1'($urandom_range(0, 1)); i_boffs[k] = $urandom;
      end
      o_gnt = ($urandom_range(0, 3) != 0);
      o_rdata = $urandom; o_ropc = 1'($urandom_range(0, 1));
      o_rvalid = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, NB - 1));
      clear = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
